// File: rtl/music_vga_pkg.sv
// Shared definitions for the music device's VGA drawing path: screen size,
// colour constants, draw FSM encoding and the buffered note event record.
package music_vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK      = 3'b000;
  localparam logic [2:0] COL_PRESS_BASE = 3'b100;

  // note(4) + octave(2) + make_break(1)
  localparam int EVT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAW,
    ST_CLEAR
  } draw_state_e;

  typedef struct packed {
    logic [3:0] note;
    logic [1:0] octave;
    logic       make_break;
  } note_evt_t;

  // A press lights the tile in the octave's hue; a release paints it black.
  function automatic logic [2:0] tileColour(input note_evt_t evt);
    return evt.make_break ? (COL_PRESS_BASE | {1'b0, evt.octave}) : COL_BLACK;
  endfunction

endpackage

// File: rtl/note_event_fifo.sv
// Small synchronous FIFO that buffers note events while a tile or a clear
// is being drawn. A pop frees a slot for a push in the same cycle, and a
// flush discards everything, including any push or pop in that cycle.
module note_event_fifo
  import music_vga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EVT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr_q == rdPtr_q);
  assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPop  = pop && !empty && !flush;
  assign doPush = push && (!full || doPop) && !flush;
  assign dout   = mem_q[rdPtr_q[AW-1:0]];

  // Advance the pointers; a flush returns both to the start.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + {{AW{1'b0}}, 1'b1};
      if (doPop)  rdPtr_d = rdPtr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Pointer registers, emptied by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/note_tile_draw_controller.sv
// Owns the single vga_adapter plot port: buffers note press/release events,
// draws each one as an 8x8 tile in a 12-note x 4-octave grid, one pixel per
// cycle, and performs full-screen black clears that take priority over
// queued events. Plot outputs are registered, so the first pixel appears
// one cycle after the FSM enters DRAW or CLEAR.
module note_tile_draw_controller
  import music_vga_pkg::*;
#(
  parameter int TILE_W     = 8,
  parameter int TILE_H     = 8,
  parameter int TILE_GAP   = 2,
  parameter int X_ORIGIN   = 8,
  parameter int Y_ORIGIN   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       note_valid,
  input  logic [3:0] note,
  input  logic [1:0] octave,
  input  logic       make_break,
  input  logic       clear_req,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       fifo_full,
  output logic       dropped
);

  draw_state_e      state_q, state_d;
  note_evt_t        tile_q, tile_d;
  logic [7:0]       xBase_q, xBase_d;
  logic [7:0]       yBase_q, yBase_d;
  logic [7:0]       cx_q, cx_d;
  logic [6:0]       cy_q, cy_d;
  logic             clearLatch_q, clearLatch_d;
  logic             dropped_q, dropped_d;
  logic [7:0]       xOut_q, xOut_d;
  logic [6:0]       yOut_q, yOut_d;
  logic [2:0]       colour_q, colour_d;
  logic             we_q, we_d;

  logic             eventAccept;
  logic             enterClear;
  logic             fifoPop;
  logic             fifoFlush;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [EVT_W-1:0] fifoDout;

  // Notes 12..15 do not exist on the keyboard and are ignored outright.
  assign eventAccept = note_valid && (note <= 4'd11);

  note_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (eventAccept),
    .pop   (fifoPop),
    .flush (fifoFlush),
    .din   ({note, octave, make_break}),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  // Next-state logic: choose work in IDLE, compute the tile origin in LOAD,
  // then walk the tile or the whole screen in raster order.
  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    xBase_d    = xBase_q;
    yBase_d    = yBase_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    xOut_d     = xOut_q;
    yOut_d     = yOut_q;
    colour_d   = colour_q;
    we_d       = 1'b0;
    fifoPop    = 1'b0;
    fifoFlush  = 1'b0;
    enterClear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clearLatch_q) begin
          enterClear = 1'b1;
          fifoFlush  = 1'b1;
          cx_d       = '0;
          cy_d       = '0;
          state_d    = ST_CLEAR;
        end else if (!fifoEmpty) begin
          fifoPop = 1'b1;
          tile_d  = note_evt_t'(fifoDout);
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        xBase_d = 8'(X_ORIGIN) + 8'(tile_q.note) * 8'(TILE_W + TILE_GAP);
        yBase_d = 8'(Y_ORIGIN) + 8'(tile_q.octave) * 8'(TILE_H + TILE_GAP);
        cx_d    = '0;
        cy_d    = '0;
        state_d = ST_DRAW;
      end

      ST_DRAW: begin
        we_d     = 1'b1;
        xOut_d   = xBase_q + cx_q;
        yOut_d   = 7'(yBase_q + 8'(cy_q));
        colour_d = tileColour(tile_q);
        if (cx_q == 8'(TILE_W - 1)) begin
          cx_d = '0;
          if (cy_q == 7'(TILE_H - 1)) begin
            cy_d    = '0;
            state_d = ST_IDLE;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      ST_CLEAR: begin
        we_d     = 1'b1;
        xOut_d   = cx_q;
        yOut_d   = cy_q;
        colour_d = COL_BLACK;
        if (cx_q == 8'(SCREEN_W - 1)) begin
          cx_d = '0;
          if (cy_q == 7'(SCREEN_H - 1)) begin
            cy_d    = '0;
            state_d = ST_IDLE;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Entering CLEAR consumes the request; otherwise any request is held.
    clearLatch_d = enterClear ? 1'b0 : (clearLatch_q | clear_req);
    // An event is lost only when the FIFO is full and nothing leaves it.
    dropped_d    = dropped_q | (eventAccept & fifoFull & ~fifoPop);
  end

  // State, working and output registers; reset abandons any draw in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      tile_q       <= '0;
      xBase_q      <= '0;
      yBase_q      <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      clearLatch_q <= 1'b0;
      dropped_q    <= 1'b0;
      xOut_q       <= '0;
      yOut_q       <= '0;
      colour_q     <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_q       <= tile_d;
      xBase_q      <= xBase_d;
      yBase_q      <= yBase_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      clearLatch_q <= clearLatch_d;
      dropped_q    <= dropped_d;
      xOut_q       <= xOut_d;
      yOut_q       <= yOut_d;
      colour_q     <= colour_d;
      we_q         <= we_d;
    end
  end

  assign x_out     = xOut_q;
  assign y_out     = yOut_q;
  assign colour    = colour_q;
  assign writeEn   = we_q;
  assign busy      = (state_q != ST_IDLE);
  assign fifo_full = fifoFull;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_note_tile_draw_controller.sv
// Self-checking bench for note_tile_draw_controller. A pixel-stream model
// (queue of expected plots built from the tile/screen geometry) is checked
// against every writeEn cycle; directed scenarios pin latency, gaps,
// dropping, clear priority and reset behaviour with literal values.
module tb_note_tile_draw_controller;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       note_valid = 1'b0;
  logic [3:0] note = '0;
  logic [1:0] octave = '0;
  logic       make_break = 1'b0;
  logic       clear_req = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       writeEn;
  logic       busy;
  logic       fifo_full;
  logic       dropped;

  int   errors = 0;
  int   checks = 0;
  int   weCount = 0;
  logic [7:0] lastX = '0;
  logic [6:0] lastY = '0;
  pix_t expQ[$];

  note_tile_draw_controller dut (
    .clk        (clk),
    .reset      (reset),
    .note_valid (note_valid),
    .note       (note),
    .octave     (octave),
    .make_break (make_break),
    .clear_req  (clear_req),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour     (colour),
    .writeEn    (writeEn),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .dropped    (dropped)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Expected plots for one tile: origin (8,16), pitch 10 in both axes.
  function automatic void expectTile(input int nt, input int oc, input bit press);
    pix_t p;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        p.x = 8'(8 + nt * 10 + c);
        p.y = 7'(16 + oc * 10 + r);
        p.c = press ? 3'(4 + oc) : 3'd0;
        expQ.push_back(p);
      end
    end
  endfunction

  // Expected plots for a full 160x120 black sweep.
  function automatic void expectClear();
    pix_t p;
    for (int r = 0; r < 120; r++) begin
      for (int c = 0; c < 160; c++) begin
        p.x = 8'(c);
        p.y = 7'(r);
        p.c = 3'd0;
        expQ.push_back(p);
      end
    end
  endfunction

  // Compare every plotted pixel against the model stream.
  always @(negedge clk) begin
    if (reset === 1'b1 && writeEn === 1'b1) begin
      pix_t e;
      weCount++;
      lastX = x_out;
      lastY = y_out;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedPixel got x=%0d y=%0d c=%0d, expected no plot", x_out, y_out, colour);
      end else begin
        e = expQ.pop_front();
        if (x_out !== e.x || y_out !== e.y || colour !== e.c) begin
          errors++;
          $display("[TB] FAIL pixel got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                   x_out, y_out, colour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutCheck(input string name, input int n, input int limit);
    checks++;
    if (n >= limit) begin
      errors++;
      $display("[TB] FAIL %s timed out after %0d cycles, expected completion", name, n);
    end
  endtask

  // Present one event for exactly one rising edge (called just after a negedge).
  task automatic applyStimulus(input logic [3:0] n, input logic [1:0] o, input logic mb);
    note_valid = 1'b1;
    note       = n;
    octave     = o;
    make_break = mb;
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic waitFirstWrite(output int n);
    n = 0;
    while (writeEn !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    timeoutCheck("waitFirstWrite", n, 100);
  endtask

  task automatic runLength(output int len, output logic [7:0] lx, output logic [6:0] ly, output logic [2:0] lc);
    len = 0; lx = '0; ly = '0; lc = '0;
    while (writeEn === 1'b1 && len < 30000) begin
      len++;
      lx = x_out; ly = y_out; lc = colour;
      @(negedge clk);
    end
  endtask

  task automatic countGap(output int g);
    g = 0;
    while (writeEn !== 1'b1 && g < 100) begin
      g++;
      @(negedge clk);
    end
  endtask

  task automatic drainModel();
    int n = 0;
    while ((expQ.size() != 0 || busy === 1'b1 || writeEn === 1'b1) && n < 25000) begin
      @(negedge clk);
      n++;
    end
    timeoutCheck("drain", n, 25000);
    checkOutput("modelQueueEmpty", expQ.size(), 0);
  endtask

  // Hard stop if anything hangs.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, len, g, weBefore;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [2:0] lc;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_x", x_out, 0);
    checkOutput("rst_y", y_out, 0);
    checkOutput("rst_colour", colour, 0);
    checkOutput("rst_writeEn", writeEn, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fifo_full", fifo_full, 0);
    checkOutput("rst_dropped", dropped, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Invalid note is ignored
    applyStimulus(4'd13, 2'd0, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("invalidNote_busy", busy, 0);
    checkOutput("invalidNote_dropped", dropped, 0);

    // Scenario 1: note 0, octave 0 press
    expectTile(0, 0, 1'b1);
    applyStimulus(4'd0, 2'd0, 1'b1);
    waitFirstWrite(n);
    checkOutput("latency", n, 3);
    checkOutput("t0_firstX", x_out, 8);
    checkOutput("t0_firstY", y_out, 16);
    checkOutput("t0_colour", colour, 3'b100);
    checkOutput("t0_busyDuring", busy, 1);
    runLength(len, lx, ly, lc);
    checkOutput("t0_len", len, 64);
    checkOutput("t0_lastX", lx, 15);
    checkOutput("t0_lastY", ly, 23);
    checkOutput("t0_busyAfter", busy, 0);
    repeat (3) @(negedge clk);

    // Scenario 2: press then release of note 11, octave 3
    expectTile(11, 3, 1'b1);
    expectTile(11, 3, 1'b0);
    applyStimulus(4'd11, 2'd3, 1'b1);
    applyStimulus(4'd11, 2'd3, 1'b0);
    waitFirstWrite(n);
    checkOutput("t11_firstX", x_out, 118);
    checkOutput("t11_firstY", y_out, 46);
    checkOutput("t11_pressColour", colour, 3'b111);
    runLength(len, lx, ly, lc);
    checkOutput("t11_pressLen", len, 64);
    checkOutput("t11_lastX", lx, 125);
    checkOutput("t11_lastY", ly, 53);
    countGap(g);
    checkOutput("t11_gap", g, 2);
    checkOutput("t11_releaseColour", colour, 3'b000);
    runLength(len, lx, ly, lc);
    checkOutput("t11_releaseLen", len, 64);
    checkOutput("t11_releaseLastX", lx, 125);
    checkOutput("t11_releaseLastY", ly, 53);
    checkOutput("t11_busyAfter", busy, 0);
    repeat (3) @(negedge clk);

    // Scenario 3: burst of presses overflows the FIFO
    weBefore = weCount;
    for (int i = 0; i < 5; i++) expectTile(i + 1, 1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'(i + 1), 2'd1, 1'b1);
    checkOutput("burst_fifoFull", fifo_full, 1);
    checkOutput("burst_droppedBefore", dropped, 0);
    applyStimulus(4'd13, 2'd1, 1'b1);
    checkOutput("burst_invalidNoDrop", dropped, 0);
    applyStimulus(4'd6, 2'd1, 1'b1);
    checkOutput("burst_dropped", dropped, 1);
    drainModel();
    checkOutput("burst_pixels", weCount - weBefore, 320);
    checkOutput("burst_droppedSticky", dropped, 1);
    checkOutput("burst_fifoEmptyAfter", fifo_full, 0);
    repeat (3) @(negedge clk);

    // Scenario 4: clear mid-tile with two events queued
    weBefore = weCount;
    expectTile(2, 2, 1'b1);
    expectClear();
    applyStimulus(4'd2, 2'd2, 1'b1);
    applyStimulus(4'd3, 2'd2, 1'b1);
    applyStimulus(4'd4, 2'd2, 1'b1);
    waitFirstWrite(n);
    repeat (10) @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    drainModel();
    checkOutput("clear_pixels", weCount - weBefore, 19264);
    checkOutput("clear_lastX", lastX, 159);
    checkOutput("clear_lastY", lastY, 119);
    repeat (10) @(negedge clk);
    checkOutput("clear_queueDiscarded", weCount - weBefore, 19264);
    checkOutput("clear_busyAfter", busy, 0);

    // Scenario 5: press arriving during a clear is kept
    expectClear();
    expectTile(5, 0, 1'b1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    waitFirstWrite(n);
    repeat (50) @(negedge clk);
    applyStimulus(4'd5, 2'd0, 1'b1);
    n = 0;
    while (writeEn === 1'b1 && n < 25000) begin
      @(negedge clk);
      n++;
    end
    timeoutCheck("clearEnd", n, 25000);
    countGap(g);
    checkOutput("afterClear_gap", g, 2);
    checkOutput("afterClear_firstX", x_out, 58);
    runLength(len, lx, ly, lc);
    checkOutput("afterClear_len", len, 64);
    drainModel();
    repeat (3) @(negedge clk);

    // Scenario 6: reset at pixel 30 of a tile with another event queued
    expectTile(7, 2, 1'b1);
    applyStimulus(4'd7, 2'd2, 1'b1);
    applyStimulus(4'd8, 2'd2, 1'b1);
    waitFirstWrite(n);
    repeat (29) @(negedge clk);
    reset = 1'b0;
    #1;
    expQ.delete();
    checkOutput("midReset_writeEn", writeEn, 0);
    checkOutput("midReset_x", x_out, 0);
    checkOutput("midReset_y", y_out, 0);
    checkOutput("midReset_colour", colour, 0);
    checkOutput("midReset_busy", busy, 0);
    checkOutput("midReset_dropped", dropped, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    weBefore = weCount;
    repeat (20) @(negedge clk);
    checkOutput("midReset_noResume", weCount - weBefore, 0);
    checkOutput("midReset_busyAfter", busy, 0);
    checkOutput("midReset_fifoFull", fifo_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
